// File: rtl/wbs_row_assembler_pkg.sv
// Shared constants for the Wishbone row assembler: address tags, FSM states, default widths.
package wbs_row_assembler_pkg;

   localparam logic [1:0] TAG_DATA  = 2'b01;
   localparam logic [1:0] TAG_INSTR = 2'b10;

   localparam int unsigned DEF_WB_WIDTH    = 32;
   localparam int unsigned DEF_DATA_WORDS  = 3;
   localparam int unsigned DEF_INSTR_WORDS = 2;
   localparam int unsigned DEF_ADDR_WIDTH  = 16;

   typedef enum logic [0:0] {
      StIdle,
      StCollect
   } wbs_state_e;

   function automatic int unsigned max_words(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/wbs_row_packer.sv
// Slot register array that gathers beats into a row, first beat in the most-significant slot.
module wbs_row_packer #(
   parameter int unsigned WB_WIDTH  = 32,
   parameter int unsigned MAX_WORDS = 3,
   localparam int unsigned IDX_W    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          clear_i,
   input  logic                          capture_i,
   input  logic [IDX_W-1:0]              last_idx_i,
   input  logic [WB_WIDTH-1:0]           data_i,
   output logic [MAX_WORDS*WB_WIDTH-1:0] row_o,
   output logic                          row_done_o
);

   logic [WB_WIDTH-1:0] slot_q [MAX_WORDS];
   logic [IDX_W-1:0]    idx_q, idx_d;

   assign row_done_o = capture_i && (idx_q == last_idx_i);

   always_comb begin
      idx_d = idx_q;
      if (clear_i) begin
         idx_d = '0;
      end else if (capture_i) begin
         idx_d = row_done_o ? '0 : idx_q + 1'b1;
      end
   end

   // Row view already includes the beat being captured so the top can commit on the same edge.
   always_comb begin
      row_o = '0;
      for (int unsigned i = 0; i < MAX_WORDS; i++) begin
         row_o[(MAX_WORDS-1-i)*WB_WIDTH +: WB_WIDTH] =
            (capture_i && (idx_q == IDX_W'(i))) ? data_i : slot_q[i];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx_q <= '0;
         for (int i = 0; i < int'(MAX_WORDS); i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         idx_q <= idx_d;
         if (capture_i && !clear_i) begin
            slot_q[idx_q] <= data_i;
         end
      end
   end

endmodule

// File: rtl/wbs_row_assembler.sv
// Wishbone write slave assembling beats into data rows / instruction words.
// Define WBS_BURST_EN to let one CYC_I assertion commit successive rows at incrementing addresses.
module wbs_row_assembler
   import wbs_row_assembler_pkg::*;
#(
   parameter int unsigned WB_WIDTH    = DEF_WB_WIDTH,
   parameter int unsigned DATA_WORDS  = DEF_DATA_WORDS,
   parameter int unsigned INSTR_WORDS = DEF_INSTR_WORDS,
   parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
   input  logic                            CLK_I,
   input  logic                            RST_I,
   input  logic                            CYC_I,
   input  logic                            STB_I,
   input  logic                            WE_I,
   input  logic [WB_WIDTH-1:0]             DAT_I,
   input  logic [WB_WIDTH-1:0]             ADR_I,
   input  logic [1:0]                      TGA_I,
   input  logic                            MST_I,
   output logic                            ACK_O,
   output logic [ADDR_WIDTH-1:0]           oDataWriteAddress,
   output logic [WB_WIDTH*DATA_WORDS-1:0]  oDataBus,
   output logic                            oDataWriteEnable,
   output logic [ADDR_WIDTH-1:0]           oInstructionWriteAddress,
   output logic [WB_WIDTH*INSTR_WORDS-1:0] oInstructionBus,
   output logic                            oInstructionWriteEnable
);

   localparam int unsigned MAX_WORDS = max_words(DATA_WORDS, INSTR_WORDS);
   localparam int unsigned IDX_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam int unsigned ROW_W     = MAX_WORDS * WB_WIDTH;

   wbs_state_e            state_q, state_d;
   logic [1:0]            tag_q, tag_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  drain_q, drain_d;
   logic                  ack_q;

   logic [ADDR_WIDTH-1:0]           data_addr_q, instr_addr_q;
   logic [WB_WIDTH*DATA_WORDS-1:0]  data_bus_q;
   logic [WB_WIDTH*INSTR_WORDS-1:0] instr_bus_q;
   logic                            data_we_q, instr_we_q;

   logic                  accept, capture, row_done;
   logic [1:0]            cur_tag;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [IDX_W-1:0]      last_idx;
   logic [ROW_W-1:0]      row;
   logic                  commit_data, commit_instr;
   logic                  unused_adr;

   assign unused_adr = ^ADR_I[WB_WIDTH-1:ADDR_WIDTH];

   assign accept   = CYC_I & STB_I & WE_I & ~ACK_O;
   assign capture  = accept & ~drain_q;
   assign cur_tag  = (state_q == StIdle) ? TGA_I : tag_q;
   assign cur_addr = (state_q == StIdle) ? ADR_I[ADDR_WIDTH-1:0] : addr_q;

   // Discard tags collapse to single-beat rows that are acked but never written.
   always_comb begin
      last_idx = '0;
      case (cur_tag)
         TAG_DATA:  last_idx = IDX_W'(DATA_WORDS - 1);
         TAG_INSTR: last_idx = IDX_W'(INSTR_WORDS - 1);
         default:   last_idx = '0;
      endcase
   end

   wbs_row_packer #(
      .WB_WIDTH  (WB_WIDTH),
      .MAX_WORDS (MAX_WORDS)
   ) u_packer (
      .clk_i      (CLK_I),
      .rst_i      (RST_I),
      .clear_i    (~CYC_I),
      .capture_i  (capture),
      .last_idx_i (last_idx),
      .data_i     (DAT_I),
      .row_o      (row),
      .row_done_o (row_done)
   );

   assign commit_data  = row_done & MST_I & (cur_tag == TAG_DATA);
   assign commit_instr = row_done & MST_I & (cur_tag == TAG_INSTR);

   always_comb begin
      state_d = state_q;
      tag_d   = tag_q;
      addr_d  = addr_q;
      drain_d = drain_q;
      if (!CYC_I) begin
         state_d = StIdle;
         drain_d = 1'b0;
      end else if (capture) begin
         state_d = StCollect;
         tag_d   = cur_tag;
         addr_d  = cur_addr;
         if (row_done) begin
`ifdef WBS_BURST_EN
            addr_d = cur_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`else
            drain_d = 1'b1;
`endif
         end
      end
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q      <= StIdle;
         tag_q        <= '0;
         addr_q       <= '0;
         drain_q      <= 1'b0;
         ack_q        <= 1'b0;
         data_addr_q  <= '0;
         data_bus_q   <= '0;
         data_we_q    <= 1'b0;
         instr_addr_q <= '0;
         instr_bus_q  <= '0;
         instr_we_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         tag_q      <= tag_d;
         addr_q     <= addr_d;
         drain_q    <= drain_d;
         ack_q      <= accept;
         data_we_q  <= commit_data;
         instr_we_q <= commit_instr;
         if (commit_data) begin
            data_bus_q  <= row[ROW_W-1 -: WB_WIDTH*DATA_WORDS];
            data_addr_q <= cur_addr;
         end
         if (commit_instr) begin
            instr_bus_q  <= row[ROW_W-1 -: WB_WIDTH*INSTR_WORDS];
            instr_addr_q <= cur_addr;
         end
      end
   end

   assign ACK_O                    = ack_q;
   assign oDataWriteAddress        = data_addr_q;
   assign oDataBus                 = data_bus_q;
   assign oDataWriteEnable         = data_we_q;
   assign oInstructionWriteAddress = instr_addr_q;
   assign oInstructionBus          = instr_bus_q;
   assign oInstructionWriteEnable  = instr_we_q;

endmodule

// File: doc/wbs_row_assembler.md
# wbs_row_assembler

Parametrised Wishbone slave that assembles consecutive 32-bit write beats into full-width data rows or instruction words and commits them to the data memory or instruction ROM write ports. It is the successor of the fixed three-word slave: fully synchronous to CLK_I (no CYC_I-clocked flops), configurable row width, tag-decoded row length, auto-incrementing burst addressing and clean partial-row abort. It sits between the external Wishbone master (host/loader) and the core's memory write ports.

## Interface
- WB_WIDTH, 32, width of one Wishbone beat
- DATA_WORDS, 3, beats per data row
- INSTR_WORDS, 2, beats per instruction word
- ADDR_WIDTH, 16, width of write addresses
- CLK_I  in  1  clock; all logic on rising edge
- RST_I  in  1  synchronous active-high reset
- CYC_I  in  1  Wishbone cycle valid
- STB_I  in  1  strobe
- WE_I  in  1  write enable (reads not supported; read beats never acked)
- DAT_I  in  WB_WIDTH  write data
- ADR_I  in  WB_WIDTH  start address; low ADDR_WIDTH bits used
- TGA_I  in  2  address tag: 2'b01 data, 2'b10 instruction, other = discard
- MST_I  in  1  master grant; commits only while high
- ACK_O  out  1  beat acknowledge
- oDataWriteAddress  out  ADDR_WIDTH  data row address
- oDataBus  out  WB_WIDTH*DATA_WORDS  assembled data row
- oDataWriteEnable  out  1  one-cycle data commit pulse
- oInstructionWriteAddress  out  ADDR_WIDTH  instruction address
- oInstructionBus  out  WB_WIDTH*INSTR_WORDS  assembled instruction
- oInstructionWriteEnable  out  1  one-cycle instruction commit pulse

## Operation
- Beat accepted at a rising edge when CYC_I & STB_I & WE_I & !ACK_O.
- States: IDLE, COLLECT. IDLE: first accepted beat latches ADR_I[ADDR_WIDTH-1:0] into address counter, TGA_I into tag register, stores word 0, goes COLLECT. COLLECT: each accepted beat stores next word; word index increments.
- Target length: DATA_WORDS for tag 01, INSTR_WORDS for tag 10, 1 for discard tags (beats acked, nothing written).
- Word order: first beat in most-significant slot (row = {w0,w1,...}).
- Last beat of a row: slot register copied to output bus and address output; matching enable pulses if MST_I high at that edge, otherwise row dropped silently. Index clears; address counter increments by 1 (wraps modulo 2^ADDR_WIDTH).
- CYC_I low in any cycle: partial row discarded, index cleared, state IDLE; no write. Tag and address relatched at next cycle.
- Tag changes mid-cycle ignored; tag fixed per CYC_I assertion.

## Timing
- Reset: ACK_O 0, both enables 0, both buses 0, both addresses 0, state IDLE, index 0.
- ACK_O: registered; high exactly one cycle after the accepting edge; max throughput one beat per 2 cycles.
- Commit: enable pulse and updated bus/address valid in the cycle after the last beat's accepting edge (same cycle as its ACK_O); pulse exactly one cycle wide.
- Outputs hold last committed value between commits.
- RST_I mid-row: all state cleared at that edge; no commit, no ACK_O the following cycle.
- CYC_I dropping in the same cycle ACK_O is high: ACK still completes; no further capture.

## Configuration
- WBS_BURST_EN defined: after a commit, further beats in the same CYC_I assertion form subsequent rows at incremented addresses.
- Undefined: after first commit, remaining beats in that CYC_I assertion are acked but discarded; address counter does not increment.

## Structure
- Shared package: tag constants (TAG_DATA 2'b01, TAG_INSTR 2'b10), state enum, default widths.
- One sub-module: wbs_row_packer — slot register array with word index, capture enable, clear, and row-complete flag; parametrised by WB_WIDTH and max word count.

## Test plan
- Reset then data burst, ADR 0x0010, tag 01, beats A,B,C -> oDataWriteEnable pulse, oDataBus {A,B,C}, address 0x0010, ACK_O per beat one cycle later.
- Instruction write, ADR 0x0005, tag 10, beats 0x11,0x22 -> oInstructionWriteEnable pulse, bus {0x11,0x22}, address 0x0005; data enable stays 0.
- CYC_I dropped after 2 of 3 data beats, then new 3-beat row at 0x0020 -> no write for partial; one commit at 0x0020 with new data only.
- WBS_BURST_EN: 6 data beats from 0xFFFF -> commits at 0xFFFF and 0x0000 (wrap); without macro -> single commit at 0xFFFF, 6 ACKs.
- MST_I low at last beat -> no enable; tag 11 beats -> ACKs only; RST_I mid-row -> outputs zero, next row unaffected.
